// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// controller states, default sizing and the Booth bit-pair decode.
package booth_pkg;

    localparam int BOOTH_DEFAULT_WIDTH = 32;
    localparam int BOOTH_DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // {current multiplier LSB, booth bit}: 01 ends a run of ones (add),
    // 10 starts a run of ones (subtract), 00/11 are inside a run (nothing).
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper half of the product register, then a 1-bit arithmetic shift.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
    input  logic [2*WIDTH:0] i_prod,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [2*WIDTH:0] o_prod
);

    booth_op_t             w_op;
    logic signed [WIDTH:0] w_upper_ext;
    logic signed [WIDTH:0] w_mcand_ext;
    logic signed [WIDTH:0] w_sum;

    // The adder is one bit wider than the operands so its MSB is the true
    // sign even when the WIDTH-bit sum overflows; that MSB is what gets
    // shifted into the top of the register.
    always_comb begin
        w_op        = booth_decode(i_prod[1:0]);
        w_upper_ext = {i_prod[2*WIDTH], i_prod[2*WIDTH:WIDTH+1]};
        w_mcand_ext = {i_mcand[WIDTH-1], i_mcand};
        case (w_op)
            OP_ADD:  w_sum = w_upper_ext + w_mcand_ext;
            OP_SUB:  w_sum = w_upper_ext - w_mcand_ext;
            default: w_sum = w_upper_ext;
        endcase
        o_prod = {w_sum, i_prod[WIDTH:1]};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier: FSM, step counter and product register.
// Optional macro BOOTH_EARLY_TERM_EN: when the remaining multiplier bits and
// the booth bit are all equal, finish with a single arithmetic barrel shift.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_DEFAULT_WIDTH,
    parameter int CNT_W = BOOTH_DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    localparam int              PW        = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [PW-1:0]    r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;

    logic [PW-1:0]    w_step_prod;
    logic [PW-1:0]    w_run_prod;
    logic             w_early;
    logic             w_last_step;
    logic             w_prod_exc;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_prod  (r_prod),
        .i_mcand (r_mcand),
        .o_prod  (w_step_prod)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [WIDTH:0]   w_tail_mask;
    logic [WIDTH:0]   w_tail;
    logic [CNT_W:0]   w_shamt;
    logic [PW-1:0]    w_early_prod;

    // With k steps done, bits [WIDTH-k:1] are the unconsumed multiplier bits
    // and bit 0 the booth bit; if they are uniform every remaining step is a
    // NOP, so the rest of the work is WIDTH-k arithmetic shifts at once.
    always_comb begin
        w_tail_mask  = {(WIDTH+1){1'b1}} >> r_cnt;
        w_tail       = r_prod[WIDTH:0] & w_tail_mask;
        w_early      = (w_tail == '0) || (w_tail == w_tail_mask);
        w_shamt      = (CNT_W+1)'(WIDTH) - {1'b0, r_cnt};
        w_early_prod = $signed(r_prod) >>> w_shamt;
        w_run_prod   = w_early ? w_early_prod : w_step_prod;
    end
`else
    // Fixed-latency build: every RUN cycle is one ordinary Booth step.
    always_comb begin
        w_early    = 1'b0;
        w_run_prod = w_step_prod;
    end
`endif

    assign w_last_step = (r_cnt == LAST_STEP);
    assign w_prod_exc  = (r_prod[2*WIDTH:WIDTH+1] != {WIDTH{r_prod[WIDTH]}});

    // State register.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a start pulse wins in every state (abort/restart).
    always_comb begin
        w_next_state = r_state;
        if (ctrl_MULT) begin
            w_next_state = RUN;
        end else begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                RUN:     w_next_state = (w_early || w_last_step) ? DONE : RUN;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Outputs: live product during DONE, held copy otherwise.
    always_comb begin
        data_resultRDY = (r_state == DONE);
        data_busy      = (r_state == RUN);
        data_result    = r_result;
        data_exception = r_exc;
        if (r_state == DONE) begin
            data_result    = r_prod[WIDTH:1];
            data_exception = w_prod_exc;
        end
    end

    // Product register, step counter and multiplicand latch.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_prod  <= '0;
            r_cnt   <= '0;
            r_mcand <= '0;
        end else if (ctrl_MULT) begin
            r_prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            r_cnt   <= '0;
            r_mcand <= data_operandA;
        end else if (r_state == RUN) begin
            r_prod  <= w_run_prod;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Capture the finished result so it stays visible until the next DONE.
    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (r_state == DONE) begin
            r_result <= r_prod[WIDTH:1];
            r_exc    <= w_prod_exc;
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq against a plain-arithmetic model.
module tb_booth_mult_seq;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          ctrl_MULT;
    logic [W-1:0]  data_operandA;
    logic [W-1:0]  data_operandB;
    logic [W-1:0]  data_result;
    logic          data_exception;
    logic          data_resultRDY;
    logic          data_busy;

    int checks = 0;
    int errors = 0;

    booth_mult_seq dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: full signed product.
    function automatic logic signed [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] pa;
        logic signed [63:0] pb;
        pa = {{32{a[W-1]}}, a};
        pb = {{32{b[W-1]}}, b};
        return pa * pb;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] p;
        p = ref_prod(a, b);
        return p[W-1:0];
    endfunction

    function automatic logic ref_exc(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] p;
        p = ref_prod(a, b);
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    // Cycle (counting the start cycle as 0) on which the result pulse appears.
    function automatic int exp_latency(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
        logic booth;
        logic uniform;
        for (int k = 0; k < W; k++) begin
            booth   = (k == 0) ? 1'b0 : b[k-1];
            uniform = 1'b1;
            for (int j = k; j < W; j++) begin
                if (b[j] != booth) uniform = 1'b0;
            end
            if (uniform) return k + 2;
        end
        return W + 1;
`else
        return (b === b) ? W + 1 : W + 1;
`endif
    endfunction

    // One complete multiplication with full result/latency/hold checking.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        int            lat;
        logic [W-1:0]  held;
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = 1;
        checks++;
        if (data_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_cycle1: got %b want 1", name, data_busy);
        end
        while (data_resultRDY !== 1'b1 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        checks++;
        if (data_resultRDY !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no data_resultRDY within %0d cycles", name, lat);
        end else begin
            if (lat !== exp_latency(b)) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, exp_latency(b));
            end
            checks++;
            if (data_result !== ref_result(a, b)) begin
                errors++;
                $display("FAIL %s result: a=%h b=%h got %h want %h", name, a, b, data_result, ref_result(a, b));
            end
            checks++;
            if (data_exception !== ref_exc(a, b)) begin
                errors++;
                $display("FAIL %s exception: a=%h b=%h got %b want %b", name, a, b, data_exception, ref_exc(a, b));
            end
            checks++;
            if (data_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_done: got %b want 0", name, data_busy);
            end
            held = data_result;
            @(negedge clock);
            @(negedge clock);
            checks++;
            if (data_resultRDY !== 1'b0 || data_result !== held) begin
                errors++;
                $display("FAIL %s hold: rdy=%b result=%h want rdy=0 result=%h", name, data_resultRDY, data_result, held);
            end
        end
    endtask

    task automatic test_reset();
        ctrl_reset    = 1'b0;
        ctrl_MULT     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (data_result !== '0) begin errors++; $display("FAIL reset result: got %h want 0", data_result); end
        checks++;
        if (data_exception !== 1'b0) begin errors++; $display("FAIL reset exception: got %b want 0", data_exception); end
        checks++;
        if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset rdy: got %b want 0", data_resultRDY); end
        checks++;
        if (data_busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", data_busy); end
        ctrl_reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_op(32'd3, 32'd5, "small_pos");
        run_op(-32'sd7, 32'd6, "neg_prod");
        run_op(32'h0001_0000, 32'h0001_0000, "ovf_big");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, "ovf_minneg");
    endtask

    task automatic test_restart();
        int rdy_cycles[$];
        int exp_cycles[$];
        int l1;
        l1 = exp_latency(32'd3);
        if (l1 <= 10) exp_cycles.push_back(l1);
        exp_cycles.push_back(10 + exp_latency(32'd4));
        for (int c = 0; c <= 70; c++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_cycles.push_back(c);
            ctrl_MULT     = (c == 0 || c == 10);
            data_operandA = (c == 0) ? 32'd2 : (c == 10) ? 32'd4 : $urandom;
            data_operandB = (c == 0) ? 32'd3 : (c == 10) ? 32'd4 : $urandom;
        end
        checks++;
        if (rdy_cycles.size() !== exp_cycles.size()) begin
            errors++;
            $display("FAIL restart pulse_count: got %0d want %0d", rdy_cycles.size(), exp_cycles.size());
        end else begin
            foreach (exp_cycles[i]) begin
                checks++;
                if (rdy_cycles[i] !== exp_cycles[i]) begin
                    errors++;
                    $display("FAIL restart pulse_cycle[%0d]: got %0d want %0d", i, rdy_cycles[i], exp_cycles[i]);
                end
            end
        end
        checks++;
        if (data_result !== 32'd16 || data_exception !== 1'b0) begin
            errors++;
            $display("FAIL restart result: got %h exc %b want 00000010 exc 0", data_result, data_exception);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clock);
            ctrl_MULT     = (c == 0);
            data_operandA = 32'd9;
            data_operandB = 32'd9;
        end
        ctrl_reset = 1'b0;
        #1;
        checks++;
        if (data_result !== '0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || data_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs: result=%h exc=%b rdy=%b busy=%b want all 0",
                     data_result, data_exception, data_resultRDY, data_busy);
        end
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid stale_pulse: got %0d pulses want 0", pulses);
        end
        run_op(32'd9, 32'd9, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        int lat;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = a1; data_operandB = b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        lat = 1;
        while (data_resultRDY !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== ref_result(a1, b1) || lat !== exp_latency(b1)) begin
            errors++;
            $display("FAIL b2b first: rdy=%b lat=%0d result=%h want lat=%0d result=%h",
                     data_resultRDY, lat, data_result, exp_latency(b1), ref_result(a1, b1));
        end
        ctrl_MULT = 1'b1; data_operandA = a2; data_operandB = b2;
        @(negedge clock);
        ctrl_MULT = 1'b0; data_operandA = $urandom; data_operandB = $urandom;
        lat = 1;
        while (data_resultRDY !== 1'b1 && lat < 100) begin @(negedge clock); lat++; end
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== ref_result(a2, b2) ||
            data_exception !== ref_exc(a2, b2) || lat !== exp_latency(b2)) begin
            errors++;
            $display("FAIL b2b second: rdy=%b lat=%0d result=%h exc=%b want lat=%0d result=%h exc=%b",
                     data_resultRDY, lat, data_result, data_exception, exp_latency(b2),
                     ref_result(a2, b2), ref_exc(a2, b2));
        end
        @(negedge clock);
    endtask

    task automatic test_extremes();
        logic [W-1:0] vals [5];
        int           order [25];
        int           j, t;
        logic [W-1:0] a, b;
        vals[0] = 32'h0000_0000;
        vals[1] = 32'h0000_0001;
        vals[2] = 32'hFFFF_FFFF;
        vals[3] = 32'h7FFF_FFFF;
        vals[4] = 32'h8000_0000;
        for (int i = 0; i < 25; i++) order[i] = i;
        for (int i = 24; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 25; i++) begin
            run_op(vals[order[i] / 5], vals[order[i] % 5], "extreme");
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = $signed($urandom) >>> $urandom_range(0, 31);
            run_op(a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        test_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
